// File: rtl/video_timing_gen.sv
// ============================================================================
// video_timing_gen : raster timing (de/hsync/vsync), coordinates and strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   LEAD      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (c_h_total > 4096 || c_v_total > 4096 ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      LEAD < 0 || LEAD >= c_h_total) begin : g_param_check
    $error("video_timing_gen: invalid timing parameters");
  end

  localparam logic [11:0] c_h_last = 12'(c_h_total - 1);
  localparam logic [11:0] c_v_last = 12'(c_v_total - 1);
  localparam logic [11:0] c_lead   = 12'(LEAD);
  // 13-bit bounds so that a 4096-wide region still compares correctly
  localparam logic [12:0] c_h_act  = 13'(H_ACTIVE);
  localparam logic [12:0] c_hs_beg = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] c_hs_end = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] c_v_act  = 13'(V_ACTIVE);
  localparam logic [12:0] c_vs_beg = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] c_vs_end = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_q, v_q, hl_q, vl_q;
  logic [11:0] h_d, v_d, hl_d, vl_d;
  logic        de_q, hsync_q, vsync_q, req_q, line_start_q, frame_start_q;
  logic        de_d, hsync_d, vsync_d, req_d;
  logic [11:0] pix_x_q, pix_y_q;

  function automatic logic [23:0] advance(input logic [11:0] h, input logic [11:0] v);
    logic [11:0] hn, vn;
    hn = (h == c_h_last) ? 12'd0 : h + 12'd1;
    vn = v;
    if (h == c_h_last) vn = (v == c_v_last) ? 12'd0 : v + 12'd1;
    return {hn, vn};
  endfunction

  always_comb begin
    {h_d, v_d}   = advance(h_q, v_q);
    {hl_d, vl_d} = advance(hl_q, vl_q);
    de_d    = ({1'b0, h_q} < c_h_act) && ({1'b0, v_q} < c_v_act);
    req_d   = ({1'b0, hl_q} < c_h_act) && ({1'b0, vl_q} < c_v_act);
    hsync_d = (({1'b0, h_q} >= c_hs_beg) && ({1'b0, h_q} < c_hs_end)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = (({1'b0, v_q} >= c_vs_beg) && ({1'b0, v_q} < c_vs_end)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= 12'd0;
      v_q           <= 12'd0;
      hl_q          <= c_lead;
      vl_q          <= 12'd0;
      de_q          <= 1'b0;
      req_q         <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      pix_x_q       <= 12'd0;
      pix_y_q       <= 12'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (en) begin
      h_q           <= h_d;
      v_q           <= v_d;
      hl_q          <= hl_d;
      vl_q          <= vl_d;
      de_q          <= de_d;
      req_q         <= req_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_x_q       <= h_q;
      pix_y_q       <= v_q;
      line_start_q  <= (h_q == 12'd0);
      frame_start_q <= (h_q == 12'd0) && (v_q == 12'd0);
    end else begin
      // Strobes mark one emission, so they drop on idle cycles
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign req         = req_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// tb_video_timing_gen : directed bench on default and 8x6 small rasters
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b1;

  logic        d_de, d_hs, d_vs, d_req, d_ls, d_fs;
  logic [11:0] d_x, d_y;
  logic        a_de, a_hs, a_vs, a_req, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic        b_de, b_hs, b_vs, b_req, b_ls, b_fs;
  logic [11:0] b_x, b_y;
  logic        p_de, p_hs, p_vs, p_req, p_ls, p_fs;
  logic [11:0] p_x, p_y;

  video_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en), .de(d_de), .hsync(d_hs), .vsync(d_vs), .req(d_req),
    .pix_x(d_x), .pix_y(d_y), .line_start(d_ls), .frame_start(d_fs));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .LEAD(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .de(a_de), .hsync(a_hs), .vsync(a_vs), .req(a_req),
    .pix_x(a_x), .pix_y(a_y), .line_start(a_ls), .frame_start(a_fs));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .LEAD(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .de(b_de), .hsync(b_hs), .vsync(b_vs), .req(b_req),
    .pix_x(b_x), .pix_y(b_y), .line_start(b_ls), .frame_start(b_fs));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .LEAD(0),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_p (
    .clk(clk), .rst(rst), .en(en), .de(p_de), .hsync(p_hs), .vsync(p_vs), .req(p_req),
    .pix_x(p_x), .pix_y(p_y), .line_start(p_ls), .frame_start(p_fs));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Small raster reference: H_TOTAL=8, V_TOTAL=6, emission k is (k%8, (k/8)%6)
  function automatic logic m_de(input int k);
    return ((k % 8) < 4) && (((k / 8) % 6) < 3);
  endfunction
  function automatic logic m_hs(input int k, input logic pol);
    return ((k % 8) == 5 || (k % 8) == 6) ? pol : ~pol;
  endfunction
  function automatic logic m_vs(input int k, input logic pol);
    return (((k / 8) % 6) == 4) ? pol : ~pol;
  endfunction

  typedef struct {
    int   k;
    logic de, hs, vs, ls, fs;
    int   x, y;
  } vec_t;

  vec_t vecs[16];

  logic        r_de[200], r_hs[200], r_vs[200], r_ls[200], r_fs[200];
  logic        r_areq[200], r_breq[200], r_phs[200], r_pvs[200];
  logic [11:0] r_x[200], r_y[200];

  initial begin
    int nreq;
    int e;
    int fs_first, fs_second;
    logic emitted;

    vecs[0]  = '{0,  1, 1, 1, 1, 1, 0, 0};
    vecs[1]  = '{3,  1, 1, 1, 0, 0, 3, 0};
    vecs[2]  = '{4,  0, 1, 1, 0, 0, 4, 0};
    vecs[3]  = '{5,  0, 0, 1, 0, 0, 5, 0};
    vecs[4]  = '{6,  0, 0, 1, 0, 0, 6, 0};
    vecs[5]  = '{7,  0, 1, 1, 0, 0, 7, 0};
    vecs[6]  = '{8,  1, 1, 1, 1, 0, 0, 1};
    vecs[7]  = '{17, 1, 1, 1, 0, 0, 1, 2};
    vecs[8]  = '{24, 0, 1, 1, 1, 0, 0, 3};
    vecs[9]  = '{32, 0, 1, 0, 1, 0, 0, 4};
    vecs[10] = '{37, 0, 0, 0, 0, 0, 5, 4};
    vecs[11] = '{39, 0, 1, 0, 0, 0, 7, 4};
    vecs[12] = '{40, 0, 1, 1, 1, 0, 0, 5};
    vecs[13] = '{47, 0, 1, 1, 0, 0, 7, 5};
    vecs[14] = '{48, 1, 1, 1, 1, 1, 0, 0};
    vecs[15] = '{96, 1, 1, 1, 1, 1, 0, 0};

    // Reset held for three clocks with en high
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) step();
    chk("rst_de",  d_de, 0);
    chk("rst_req", d_req, 0);
    chk("rst_hs",  d_hs, 1);
    chk("rst_vs",  d_vs, 1);
    chk("rst_x",   d_x, 0);
    chk("rst_fs",  a_fs, 0);
    rst = 1'b0;

    for (int k = 0; k < 200; k++) begin
      step();
      if (k == 0) begin
        chk("first_de",  d_de, 1);
        chk("first_x",   d_x, 0);
        chk("first_y",   d_y, 0);
        chk("first_fs",  d_fs, 1);
        chk("first_req", d_req, 1);
      end
      r_de[k] = a_de;  r_hs[k] = a_hs;  r_vs[k] = a_vs;
      r_ls[k] = a_ls;  r_fs[k] = a_fs;  r_x[k] = a_x;  r_y[k] = a_y;
      r_areq[k] = a_req; r_breq[k] = b_req;
      r_phs[k] = p_hs; r_pvs[k] = p_vs;
    end

    for (int i = 0; i < 16; i++) begin
      int k;
      k = vecs[i].k;
      chk($sformatf("vec%0d_de", k), r_de[k], vecs[i].de);
      chk($sformatf("vec%0d_hs", k), r_hs[k], vecs[i].hs);
      chk($sformatf("vec%0d_vs", k), r_vs[k], vecs[i].vs);
      chk($sformatf("vec%0d_ls", k), r_ls[k], vecs[i].ls);
      chk($sformatf("vec%0d_fs", k), r_fs[k], vecs[i].fs);
      chk($sformatf("vec%0d_x", k),  r_x[k],  vecs[i].x);
      chk($sformatf("vec%0d_y", k),  r_y[k],  vecs[i].y);
    end

    for (int k = 0; k < 200; k++) begin
      chk($sformatf("de_k%0d", k),    r_de[k],   m_de(k));
      chk($sformatf("hs_k%0d", k),    r_hs[k],   m_hs(k, 1'b0));
      chk($sformatf("vs_k%0d", k),    r_vs[k],   m_vs(k, 1'b0));
      chk($sformatf("ls_k%0d", k),    r_ls[k],   (k % 8) == 0);
      chk($sformatf("fs_k%0d", k),    r_fs[k],   (k % 48) == 0);
      chk($sformatf("req0_k%0d", k),  r_areq[k], m_de(k));
      chk($sformatf("req2_k%0d", k),  r_breq[k], m_de(k + 2));
      chk($sformatf("phs_k%0d", k),   r_phs[k],  m_hs(k, 1'b1));
      chk($sformatf("pvs_k%0d", k),   r_pvs[k],  m_vs(k, 1'b1));
    end
    chk("req2_wrap_h6", r_breq[46], 1);
    chk("req2_wrap_h7", r_breq[47], 1);
    nreq = 0;
    for (int k = 48; k < 96; k++) nreq += int'(r_breq[k]);
    chk("req2_per_frame", nreq, 12);

    // en toggling: emissions on every other edge
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = 0;
    fs_first  = -1;
    fs_second = -1;
    for (int c = 0; c < 200; c++) begin
      int k;
      en = (c % 2 == 0);
      emitted = en;
      step();
      if (emitted) e++;
      k = e - 1;
      chk($sformatf("en_de_c%0d", c), a_de, m_de(k));
      chk($sformatf("en_hs_c%0d", c), a_hs, m_hs(k, 1'b0));
      chk($sformatf("en_vs_c%0d", c), a_vs, m_vs(k, 1'b0));
      chk($sformatf("en_x_c%0d", c),  a_x,  k % 8);
      chk($sformatf("en_y_c%0d", c),  a_y,  (k / 8) % 6);
      chk($sformatf("en_ls_c%0d", c), a_ls, emitted && (k % 8) == 0);
      chk($sformatf("en_fs_c%0d", c), a_fs, emitted && (k % 48) == 0);
      if (a_fs === 1'b1) begin
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
    end
    chk("en_fs_period", fs_second - fs_first, 96);

    // Mid-frame reset at emission (v=2,h=3)
    en  = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("mid_x_before", a_x, 3);
    chk("mid_y_before", a_y, 2);
    rst = 1'b1;
    step();
    chk("mid_rst_de", a_de, 0);
    chk("mid_rst_hs", a_hs, 1);
    chk("mid_rst_vs", a_vs, 1);
    chk("mid_rst_x",  a_x, 0);
    chk("mid_rst_y",  a_y, 0);
    chk("mid_rst_ls", a_ls, 0);
    chk("mid_rst_fs", a_fs, 0);
    rst = 1'b0;
    step();
    chk("mid_after_x",  a_x, 0);
    chk("mid_after_y",  a_y, 0);
    chk("mid_after_fs", a_fs, 1);
    chk("mid_after_de", a_de, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that produces de, hsync and vsync for the TMDS encoder stage.
- hsync/vsync drive c0/c1 of channel 0; de drives de on all three channels.
- Also emits pixel coordinates, line/frame strobes, and a look-ahead pixel request so the upstream pixel source can pre-fetch with fixed latency.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync
- LEAD, 1, emissions by which req precedes de; 0 ≤ LEAD < H_TOTAL

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- en  in  1  pixel advance enable
- de  out  1  data enable
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- req  out  1  pixel request, LEAD emissions ahead of de
- pix_x  out  12  horizontal position of current emission
- pix_y  out  12  vertical position of current emission
- line_start  out  1  strobe, emission with h=0
- frame_start  out  1  strobe, emission with h=0, v=0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Both must be ≤ 4096. Elaboration error if either exceeds 4096, if any parameter is 0, or if LEAD ≥ H_TOTAL.
- Internal counters:
  - (h,v) is the next position to emit; h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
  - h increments; on wrap to 0, v increments; v wraps to 0 after V_TOTAL-1.
  - Lookahead pair (hl,vl) runs LEAD positions ahead with identical wrap rules.
- Reset (rst=1 at a clk edge):
  - h=0, v=0; (hl,vl) = position LEAD in raster order.
  - Outputs: de=0, req=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, pix_x=0, pix_y=0, line_start=0, frame_start=0.
  - Reset has priority over en and applies mid-frame without exception.
- Edge with rst=0, en=1 (emission): all outputs register the decode of (h,v), then both counter pairs advance. Outputs therefore describe the position emitted at the previous edge.
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync = HSYNC_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL
  - vsync = VSYNC_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL. vsync is line-based and changes only on emissions with h=0.
  - req = (hl < H_ACTIVE) && (vl < V_ACTIVE), so req at emission k equals de at emission k+LEAD, including wrap across line and frame.
  - pix_x = h, pix_y = v, in all regions (not gated by de).
  - line_start = (h==0); frame_start = (h==0 && v==0).
- Edge with rst=0, en=0:
  - Counters, de, hsync, vsync, req, pix_x and pix_y hold.
  - line_start and frame_start clear to 0, so each strobe lasts exactly one clk per emission.
- After reset, the first emission is (0,0), with frame_start=1 and de=1.
  - The first LEAD active positions after reset receive no req; this is accepted.
  - Steady state: exactly H_ACTIVE*V_ACTIVE req emissions and de emissions per frame.
- LEAD=0: req is identical to de.

Test Plan:
- Reset, defaults, en=1: hold rst 3 clk.
  - During reset: de=0, req=0, hsync=1, vsync=1, pix_x=0.
  - First edge after release: de=1, pix_x=0, pix_y=0, frame_start=1, req=1.
- Small raster: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), LEAD=0, en=1 constant.
  - Lines 0–2: de pattern 11110000.
  - hsync=0 at h=5,6 on every line.
  - vsync=0 for all 8 emissions of v=4.
  - frame_start every 48 clk; line_start every 8 clk.
- Same raster with LEAD=2:
  - req(k)=de(k+2) for 200 emissions.
  - req=1 at (v=5,h=6) and (v=5,h=7), i.e. wrap into next frame.
  - 12 req per frame.
- en gating: en toggling 1/0 on the small raster.
  - Outputs hold on en=0 cycles; strobes are high only one clk.
  - frame_start period is 96 clk.
- Mid-frame reset: assert rst for 1 clk at emission (v=2,h=3).
  - Next cycle shows reset values.
  - Following emission is (0,0) with frame_start=1.
- Polarity: HSYNC_POL=1, VSYNC_POL=1 on the small raster.
  - hsync=1 only at h=5,6.
  - vsync=1 only on v=4; idle levels are 0.
